dma_channel: RTL and testbench

- Single-channel DMA master that copies a block of words from a source address to a destination address over the shared bus.
- Sits directly upstream of the bus arbiter: drives one `dma` request line into the arbiter and consumes that line's `grant` bit plus the shared slave `ready`.
- Each word moves as one arbitrated read beat followed by one arbitrated write beat, through a one-word holding register.

---
 rtl/bus_pkg.sv | 29 ++
 rtl/dma_addr_gen.sv | 45 ++++
 rtl/dma_channel.sv | 152 +++++++++++++++
 tb/tb_dma_channel.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions for the DMA channel and the bus arbiter: default
// widths, request-line count and the DMA channel state encoding.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;
  localparam int DMA_LINES  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_GAP     = 3'd5,
    ST_FIN     = 3'd6
  } dma_state_t;

  // States in which the channel owns, or is asking for, the bus
  function automatic logic is_beat_state(dma_state_t s);
    return (s == ST_RD_REQ) || (s == ST_RD_WAIT) ||
           (s == ST_WR_REQ) || (s == ST_WR_WAIT);
  endfunction

  function automatic logic is_wr_state(dma_state_t s);
    return (s == ST_WR_REQ) || (s == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Source/destination pointers and remaining word count for dma_channel.
// Pointers wrap modulo 2^ADDR_W; last flags the final word of the block.
module dma_addr_gen
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              rd_step,
  input  logic              wr_step,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic              last
);

  logic [LEN_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src   <= '0;
      dst   <= '0;
      count <= '0;
    end else if (load) begin
      src   <= src_addr;
      dst   <= dst_addr;
      count <= len;
    end else begin
      if (rd_step) src <= src + ADDR_W'(1);
      // The count is consumed by the write, so a word is only retired once copied
      if (wr_step) begin
        dst   <= dst + ADDR_W'(1);
        count <= count - LEN_W'(1);
      end
    end
  end

  assign last = (count == LEN_W'(1));

endmodule

// File: rtl/dma_channel.sv
// Single-channel DMA master: copies len words src->dst, one arbitrated read
// beat then one write beat per word. Define DMA_CHANNEL_BURST_EN to keep the
// bus request high between beats instead of releasing it for one cycle.
module dma_channel
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              dma,
  input  logic              grant,
  input  logic              ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_we,
  output logic              bus_oe
);

  dma_state_t        state, state_nxt;
  dma_state_t        ret_state, ret_nxt;
  logic              abort_pend;
  logic [DATA_W-1:0] hold_reg;
  logic [ADDR_W-1:0] src, dst;
  logic              last;
  logic              load, rd_step, wr_step;
  logic              beat_ok, stop_req;

  assign beat_ok  = grant & ready;
  assign stop_req = abort | abort_pend;

  dma_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len     (len),
    .rd_step (rd_step),
    .wr_step (wr_step),
    .src     (src),
    .dst     (dst),
    .last    (last)
  );

  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    load      = 1'b0;
    rd_step   = 1'b0;
    wr_step   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            load      = 1'b1;
            state_nxt = ST_RD_REQ;
          end else begin
            state_nxt = ST_FIN;
          end
        end
      end
      ST_RD_REQ, ST_RD_WAIT: begin
        // Abort may only pre-empt a read that has not been granted yet
        if (state == ST_RD_REQ && !grant && stop_req) begin
          state_nxt = ST_FIN;
        end else if (beat_ok) begin
          rd_step = 1'b1;
`ifdef DMA_CHANNEL_BURST_EN
          state_nxt = ST_WR_REQ;
`else
          state_nxt = ST_GAP;
          ret_nxt   = ST_WR_REQ;
`endif
        end else if (grant) begin
          state_nxt = ST_RD_WAIT;
        end
      end
      ST_WR_REQ, ST_WR_WAIT: begin
        if (beat_ok) begin
          wr_step = 1'b1;
          if (last || stop_req) begin
            state_nxt = ST_FIN;
          end else begin
`ifdef DMA_CHANNEL_BURST_EN
            state_nxt = ST_RD_REQ;
`else
            state_nxt = ST_GAP;
            ret_nxt   = ST_RD_REQ;
`endif
          end
        end else if (grant) begin
          state_nxt = ST_WR_WAIT;
        end
      end
      ST_GAP:  state_nxt = ret_state;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ret_state  <= ST_IDLE;
      abort_pend <= 1'b0;
      dma        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      hold_reg   <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      // An abort seen mid-word is remembered so the matching write still runs
      if (state_nxt == ST_IDLE || state_nxt == ST_FIN)
        abort_pend <= 1'b0;
      else
        abort_pend <= abort_pend | abort;
      dma    <= is_beat_state(state_nxt);
      busy   <= (state_nxt != ST_IDLE);
      done   <= (state == ST_FIN);
      bus_we <= is_wr_state(state_nxt);
      if (load)
        bus_addr <= src_addr;
      else if (state_nxt == ST_RD_REQ)
        bus_addr <= src;
      else if (state_nxt == ST_WR_REQ)
        bus_addr <= dst;
      if (rd_step) hold_reg <= bus_rdata;
    end
  end

  assign bus_wdata = hold_reg;
  assign bus_oe    = grant & is_beat_state(state);

endmodule

// File: tb/tb_dma_channel.sv
// Directed bench for dma_channel with a behavioural arbiter/slave whose grant
// and ready latencies are set per scenario. Honours DMA_CHANNEL_BURST_EN.
module tb_dma_channel;

`ifdef DMA_CHANNEL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort, grant, ready;
  logic        busy, done, dma, bus_we, bus_oe;
  logic [15:0] src_addr, dst_addr, len, bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:65535];
  int          gnt_dly, rdy_dly, gcnt, rcnt;
  bit          beat_flag;
  logic [24:0] q_beat [$];
  int          lowcnt, maxrun, run, donecnt, busycnt, dmacnt, oe_viol;

  always #5 clk = ~clk;

  dma_channel #(.ADDR_W(16), .DATA_W(8), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .abort(abort), .busy(busy), .done(done), .dma(dma), .grant(grant),
    .ready(ready), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_we(bus_we), .bus_oe(bus_oe)
  );

  // Arbiter/slave model plus monitors, all stepping on the falling edge
  initial begin : responder
    grant = 1'b0; ready = 1'b0; bus_rdata = '0;
    gcnt = 0; rcnt = 0; beat_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (beat_flag) begin
        grant = 1'b0; ready = 1'b0; gcnt = 0; beat_flag = 1'b0;
      end
      if (dma !== 1'b1) begin
        grant = 1'b0; ready = 1'b0; gcnt = 0;
      end else begin
        if (!grant) begin
          if (gcnt >= gnt_dly) begin grant = 1'b1; rcnt = 0; end
          else gcnt++;
        end
        if (grant && !ready) begin
          if (rcnt >= rdy_dly) ready = 1'b1;
          else rcnt++;
        end
      end
      #1;
      if (bus_we !== 1'b1) bus_rdata = mem[bus_addr];
      if (grant && ready) begin
        q_beat.push_back({bus_we, bus_addr, (bus_we === 1'b1) ? bus_wdata : bus_rdata});
        beat_flag = 1'b1;
      end
      if (busy === 1'b1 && dma !== 1'b1) begin
        lowcnt++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (done === 1'b1) donecnt++;
      if (busy === 1'b1) busycnt++;
      if (dma === 1'b1) dmacnt++;
      if (bus_oe === 1'b1 && grant !== 1'b1) oe_viol++;
    end
  end

  task automatic clear_mon();
    q_beat.delete();
    lowcnt = 0; maxrun = 0; run = 0; donecnt = 0; busycnt = 0; dmacnt = 0; oe_viol = 0;
  endtask

  task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges from the start pulse until done is seen (0 = timeout)
  task automatic wait_done(output int cyc);
    cyc = 1;
    #2;
    while (done !== 1'b1 && cyc < 600) begin
      @(negedge clk); #2; cyc++;
    end
    if (done !== 1'b1) cyc = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; gnt_dly = 0; rdy_dly = 0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (dma !== 1'b0) begin errors++; $display("FAIL reset_dma got %b exp 0", dma); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", bus_oe); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus_we); end
    checks++; if (bus_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", bus_addr); end
    checks++; if (bus_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h exp 00", bus_wdata); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks++; if ({busy, dma} !== 2'b00) begin errors++; $display("FAIL post_reset_idle got %b exp 00", {busy, dma}); end
  endtask

  task automatic test_basic();
    logic [24:0] exp [6];
    int cyc;
    exp = '{{1'b0, 16'h0100, 8'hA1}, {1'b1, 16'h0200, 8'hA1},
            {1'b0, 16'h0101, 8'hB2}, {1'b1, 16'h0201, 8'hB2},
            {1'b0, 16'h0102, 8'hC3}, {1'b1, 16'h0202, 8'hC3}};
    mem[16'h0100] = 8'hA1; mem[16'h0101] = 8'hB2; mem[16'h0102] = 8'hC3;
    gnt_dly = 0; rdy_dly = 1;
    clear_mon();
    pulse_start(16'h0100, 16'h0200, 16'd3);
    wait_done(cyc);
    checks++; if (cyc !== (BURST ? 14 : 19)) begin errors++; $display("FAIL basic_latency got %0d exp %0d", cyc, BURST ? 14 : 19); end
    checks++; if (q_beat.size() !== 6) begin errors++; $display("FAIL basic_beats got %0d exp 6", q_beat.size()); end
    for (int i = 0; i < 6 && i < q_beat.size(); i++) begin
      checks++;
      if (q_beat[i] !== exp[i]) begin errors++; $display("FAIL basic_beat%0d got %h exp %h", i, q_beat[i], exp[i]); end
    end
    checks++; if (donecnt !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", donecnt); end
    checks++; if (busycnt !== (BURST ? 13 : 18)) begin errors++; $display("FAIL basic_busy got %0d exp %0d", busycnt, BURST ? 13 : 18); end
    checks++; if (lowcnt !== (BURST ? 1 : 6)) begin errors++; $display("FAIL basic_dma_low got %0d exp %0d", lowcnt, BURST ? 1 : 6); end
  endtask

  task automatic test_len0();
    int cyc;
    clear_mon();
    pulse_start(16'h1234, 16'h5678, 16'd0);
    wait_done(cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL len0_latency got %0d exp 2", cyc); end
    checks++; if (dmacnt !== 0) begin errors++; $display("FAIL len0_dma got %0d exp 0", dmacnt); end
    checks++; if (busycnt !== 1) begin errors++; $display("FAIL len0_busy got %0d exp 1", busycnt); end
    checks++; if (donecnt !== 1) begin errors++; $display("FAIL len0_done got %0d exp 1", donecnt); end
    checks++; if (q_beat.size() !== 0) begin errors++; $display("FAIL len0_beats got %0d exp 0", q_beat.size()); end
  endtask

  task automatic test_stall();
    logic [24:0] exp [4];
    int cyc;
    exp = '{{1'b0, 16'h0300, 8'h11}, {1'b1, 16'h0400, 8'h11},
            {1'b0, 16'h0301, 8'h22}, {1'b1, 16'h0401, 8'h22}};
    mem[16'h0300] = 8'h11; mem[16'h0301] = 8'h22;
    gnt_dly = 10; rdy_dly = 5;
    clear_mon();
    pulse_start(16'h0300, 16'h0400, 16'd2);
    #2;
    checks++; if ({dma, bus_oe} !== 2'b10) begin errors++; $display("FAIL stall_withheld got %b exp 10", {dma, bus_oe}); end
    wait_done(cyc);
    checks++; if (cyc === 0) begin errors++; $display("FAIL stall_timeout got 0 exp done"); end
    checks++; if (q_beat.size() !== 4) begin errors++; $display("FAIL stall_beats got %0d exp 4", q_beat.size()); end
    for (int i = 0; i < 4 && i < q_beat.size(); i++) begin
      checks++;
      if (q_beat[i] !== exp[i]) begin errors++; $display("FAIL stall_beat%0d got %h exp %h", i, q_beat[i], exp[i]); end
    end
    checks++; if (oe_viol !== 0) begin errors++; $display("FAIL stall_oe_without_grant got %0d exp 0", oe_viol); end
    // Grant and ready rise together: every beat completes in its REQ state
    exp = '{{1'b0, 16'h0310, 8'h33}, {1'b1, 16'h0410, 8'h33},
            {1'b0, 16'h0311, 8'h44}, {1'b1, 16'h0411, 8'h44}};
    mem[16'h0310] = 8'h33; mem[16'h0311] = 8'h44;
    gnt_dly = 3; rdy_dly = 0;
    clear_mon();
    pulse_start(16'h0310, 16'h0410, 16'd2);
    wait_done(cyc);
    checks++; if (q_beat.size() !== 4) begin errors++; $display("FAIL same_cycle_beats got %0d exp 4", q_beat.size()); end
    for (int i = 0; i < 4 && i < q_beat.size(); i++) begin
      checks++;
      if (q_beat[i] !== exp[i]) begin errors++; $display("FAIL same_cycle_beat%0d got %h exp %h", i, q_beat[i], exp[i]); end
    end
    checks++; if (donecnt !== 1 || oe_viol !== 0) begin errors++; $display("FAIL same_cycle_done_oe got %0d/%0d exp 1/0", donecnt, oe_viol); end
  endtask

  task automatic test_abort();
    logic [24:0] exp [4];
    int cyc;
    bit found;
    exp = '{{1'b0, 16'h0500, 8'h55}, {1'b1, 16'h0600, 8'h55},
            {1'b0, 16'h0501, 8'h66}, {1'b1, 16'h0601, 8'h66}};
    mem[16'h0500] = 8'h55; mem[16'h0501] = 8'h66; mem[16'h0502] = 8'h77;
    gnt_dly = 0; rdy_dly = 3;
    clear_mon();
    pulse_start(16'h0500, 16'h0600, 16'd5);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #2;
      if (bus_oe === 1'b1 && bus_we === 1'b0 && bus_addr === 16'h0501) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_word2_read got none exp read at 0501"); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_done(cyc);
    checks++; if (cyc === 0) begin errors++; $display("FAIL abort_timeout got 0 exp done"); end
    checks++; if (q_beat.size() !== 4) begin errors++; $display("FAIL abort_beats got %0d exp 4", q_beat.size()); end
    for (int i = 0; i < 4 && i < q_beat.size(); i++) begin
      checks++;
      if (q_beat[i] !== exp[i]) begin errors++; $display("FAIL abort_beat%0d got %h exp %h", i, q_beat[i], exp[i]); end
    end
    checks++; if (donecnt !== 1) begin errors++; $display("FAIL abort_done got %0d exp 1", donecnt); end
  endtask

  task automatic test_wrap();
    logic [24:0] exp [4];
    int cyc;
    exp = '{{1'b0, 16'hFFFF, 8'h5A}, {1'b1, 16'h0010, 8'h5A},
            {1'b0, 16'h0000, 8'h6B}, {1'b1, 16'h0011, 8'h6B}};
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'h6B;
    gnt_dly = 0; rdy_dly = 0;
    clear_mon();
    pulse_start(16'hFFFF, 16'h0010, 16'd2);
    wait_done(cyc);
    checks++; if (cyc !== (BURST ? 6 : 9)) begin errors++; $display("FAIL wrap_latency got %0d exp %0d", cyc, BURST ? 6 : 9); end
    checks++; if (q_beat.size() !== 4) begin errors++; $display("FAIL wrap_beats got %0d exp 4", q_beat.size()); end
    for (int i = 0; i < 4 && i < q_beat.size(); i++) begin
      checks++;
      if (q_beat[i] !== exp[i]) begin errors++; $display("FAIL wrap_beat%0d got %h exp %h", i, q_beat[i], exp[i]); end
    end
    checks++; if (lowcnt !== (BURST ? 1 : 4)) begin errors++; $display("FAIL wrap_dma_low got %0d exp %0d", lowcnt, BURST ? 1 : 4); end
    checks++; if (maxrun !== 1) begin errors++; $display("FAIL wrap_gap_len got %0d exp 1", maxrun); end
  endtask

  task automatic test_reset_midbeat();
    logic [24:0] exp [2];
    int cyc;
    bit found;
    exp = '{{1'b0, 16'h0900, 8'h3C}, {1'b1, 16'h0A00, 8'h3C}};
    mem[16'h0700] = 8'h81; mem[16'h0701] = 8'h82; mem[16'h0900] = 8'h3C;
    gnt_dly = 0; rdy_dly = 4;
    clear_mon();
    pulse_start(16'h0700, 16'h0800, 16'd2);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #2;
      if (bus_oe === 1'b1 && bus_we === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_write_grant got none exp write beat"); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({dma, bus_oe, busy} !== 3'b000) begin errors++; $display("FAIL rst_async_drop got %b exp 000", {dma, bus_oe, busy}); end
    @(negedge clk); rst = 1'b0;
    gnt_dly = 0; rdy_dly = 1;
    clear_mon();
    pulse_start(16'h0900, 16'h0A00, 16'd1);
    wait_done(cyc);
    checks++; if (cyc !== (BURST ? 6 : 7)) begin errors++; $display("FAIL rst_rerun_latency got %0d exp %0d", cyc, BURST ? 6 : 7); end
    checks++; if (q_beat.size() !== 2) begin errors++; $display("FAIL rst_rerun_beats got %0d exp 2", q_beat.size()); end
    for (int i = 0; i < 2 && i < q_beat.size(); i++) begin
      checks++;
      if (q_beat[i] !== exp[i]) begin errors++; $display("FAIL rst_rerun_beat%0d got %h exp %h", i, q_beat[i], exp[i]); end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_abort();
    test_wrap();
    test_reset_midbeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
